dsp_result_collector: RTL and testbench

- Downstream stage of the DSP48A1 slice; consumes its P and CARRYOUT outputs.
- A valid-tracking delay line matches the slice pipeline latency, so the upstream issuer pulses IN_VALID alongside the operands it drives into the slice.
- Each tagged P result is rounded and right-shifted, saturated to OUT_W bits, then buffered in a small FIFO with a valid/ready output handshake.
- Drops caused by a full FIFO are counted and flagged.

---
 rtl/dsp_result_collector_if.sv | 27 ++
 rtl/dsp_result_collector.sv | 92 +++++++++
 tb/tb_dsp_result_collector.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dsp_result_collector_if.sv
// dsp_result_collector_if: slice-result input, FIFO output handshake and status bundle.
interface dsp_result_collector_if #(
  parameter int OUT_W = 18,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic             in_valid;
  logic [47:0]      p;
  logic             carryout;
  logic             flush;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_carry;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             ovf;
  logic [15:0]      drop_cnt;
  modport master (
    output in_valid, p, carryout, flush, out_ready,
    input  out_data, out_sat, out_carry, out_valid, count, ovf, drop_cnt
  );
  modport slave (
    input  in_valid, p, carryout, flush, out_ready,
    output out_data, out_sat, out_carry, out_valid, count, ovf, drop_cnt
  );
endinterface

// File: rtl/dsp_result_collector.sv
// dsp_result_collector: tags slice P results by latency, rounds/shifts/saturates them, and queues them in a FIFO.
module dsp_result_collector #(
  parameter int LATENCY = 4,
  parameter int SHIFT   = 4,
  parameter int OUT_W   = 18,
  parameter int DEPTH   = 8
) (
  input logic                clk,
  input logic                rst,
  dsp_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [48:0] BIAS = SHIFT > 0 ? 49'sd1 <<< (SHIFT > 0 ? SHIFT - 1 : 0) : 49'sd0;
  localparam logic signed [48:0] MAXV = (49'sd1 <<< (OUT_W - 1)) - 49'sd1;
  localparam logic signed [48:0] MINV = -(49'sd1 <<< (OUT_W - 1));
  logic [LATENCY-1:0] dl;
  logic               cap_v;
  logic signed [48:0] r;
  logic [OUT_W-1:0]   wdata;
  logic               wsat;
  logic [OUT_W-1:0]   mem_d [DEPTH];
  logic               mem_s [DEPTH];
  logic               mem_c [DEPTH];
  logic [AW-1:0]      wp, rp;
  logic [CW-1:0]      cnt;
  logic               full, pop, push, drop;
  logic [OUT_W-1:0]   last_d;
  logic               last_s, last_c;
  logic               ovf;
  logic [15:0]        drop_cnt;
  always_comb begin
    cap_v = dl[LATENCY-1];
    r     = ($signed({bus.p[47], bus.p}) + BIAS) >>> SHIFT;
    wsat  = (r > MAXV) || (r < MINV);
    wdata = r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
    full  = cnt == CW'(DEPTH);
    pop   = (cnt != '0) && bus.out_ready;
    push  = cap_v && (!full || pop);
    drop  = cap_v && full && !pop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl       <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      last_d   <= '0;
      last_s   <= 1'b0;
      last_c   <= 1'b0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (bus.flush) begin
      dl     <= '0;
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      last_d <= '0;
      last_s <= 1'b0;
      last_c <= 1'b0;
    end else begin
      dl  <= (dl << 1) | LATENCY'(bus.in_valid);
      wp  <= wp + AW'(push);
      rp  <= rp + AW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (pop) begin
        last_d <= mem_d[rp];
        last_s <= mem_s[rp];
        last_c <= mem_c[rp];
      end
      if (drop) begin
        ovf      <= 1'b1;
        drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
      end
    end
  end
  // Storage needs no reset: reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !bus.flush && !rst) begin
      mem_d[wp] <= wdata;
      mem_s[wp] <= wsat;
      mem_c[wp] <= bus.carryout;
    end
  end
  assign bus.out_valid = cnt != '0;
  assign bus.out_data  = bus.out_valid ? mem_d[rp] : last_d;
  assign bus.out_sat   = bus.out_valid ? mem_s[rp] : last_s;
  assign bus.out_carry = bus.out_valid ? mem_c[rp] : last_c;
  assign bus.count     = cnt;
  assign bus.ovf       = ovf;
  assign bus.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_dsp_result_collector.sv
// tb_dsp_result_collector: directed checks of rounding, saturation, FIFO overflow, flush and async reset.
module tb_dsp_result_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  logic [47:0] pq [4];
  logic        cq [4];
  dsp_result_collector_if #(.OUT_W(18), .DEPTH(8)) bus ();
  dsp_result_collector #(.LATENCY(4), .SHIFT(4), .OUT_W(18), .DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // One cycle: P/CARRYOUT lag the issuing IN_VALID by 4 cycles to model the slice pipeline.
  task automatic cyc(input logic iv, input logic [47:0] pv, input logic cv);
    bus.in_valid = iv;
    bus.p        = pq[3];
    bus.carryout = cq[3];
    for (int i = 3; i > 0; i--) begin
      pq[i] = pq[i-1];
      cq[i] = cq[i-1];
    end
    pq[0] = pv;
    cq[0] = cv;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 48'h0, 1'b0);
  endtask
  task automatic pop_chk(input string tag, input logic [17:0] d, input logic s, input logic c);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'h1);
    chk({tag, "_data"}, 64'(bus.out_data), 64'(d));
    chk({tag, "_sat"}, 64'(bus.out_sat), 64'(s));
    chk({tag, "_carry"}, 64'(bus.out_carry), 64'(c));
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [17:0] exp_q [8];
    for (int i = 0; i < 4; i++) begin
      pq[i] = '0;
      cq[i] = 1'b0;
    end
    bus.in_valid = 1'b0; bus.p = '0; bus.carryout = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk("rst_data", 64'(bus.out_data), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_count", 64'(bus.count), 64'h0);
    chk("rst_ovf", 64'(bus.ovf), 64'h0);
    chk("rst_drop", 64'(bus.drop_cnt), 64'h0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(1'b1, 48'd55, 1'b0);
    idle(3);
    chk("lat_early", 64'(bus.out_valid), 64'h0);
    idle(1);
    chk("lat_count", 64'(bus.count), 64'h1);
    pop_chk("r55", 18'd3, 1'b0, 1'b0);
    chk("pop_count", 64'(bus.count), 64'h0);
    chk("pop_valid", 64'(bus.out_valid), 64'h0);
    chk("hold_data", 64'(bus.out_data), 64'h3);
    cyc(1'b1, -48'sd24, 1'b0);
    cyc(1'b1, -48'sd8, 1'b0);
    cyc(1'b1, 48'sd8, 1'b1);
    idle(4);
    chk("neg_count", 64'(bus.count), 64'h3);
    pop_chk("m24", 18'h3FFFF, 1'b0, 1'b0);
    pop_chk("m8", 18'h0, 1'b0, 1'b0);
    pop_chk("p8", 18'h1, 1'b0, 1'b1);
    cyc(1'b1, 48'h010000000000, 1'b0);
    cyc(1'b1, 48'hFF0000000000, 1'b0);
    cyc(1'b1, 48'h1FFFFF, 1'b0);
    idle(4);
    pop_chk("satp", 18'h1FFFF, 1'b1, 1'b0);
    pop_chk("satn", 18'h20000, 1'b1, 1'b0);
    pop_chk("sat21", 18'h1FFFF, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 48'(16 * k), 1'b0);
    idle(4);
    chk("ovf_count", 64'(bus.count), 64'h8);
    chk("ovf_flag", 64'(bus.ovf), 64'h1);
    chk("ovf_drop", 64'(bus.drop_cnt), 64'h2);
    for (int k = 0; k < 8; k++) pop_chk("drain", 18'(k), 1'b0, 1'b0);
    chk("drain_valid", 64'(bus.out_valid), 64'h0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 48'(16 * (20 + k)), 1'b0);
    idle(4);
    chk("fill_count", 64'(bus.count), 64'h8);
    for (int k = 0; k < 4; k++) cyc(1'b1, 48'(16 * (30 + k)), 1'b0);
    bus.out_ready = 1'b1;
    cyc(1'b1, 48'(16 * 34), 1'b0);
    chk("rw_count", 64'(bus.count), 64'h8);
    cyc(1'b1, 48'(16 * 35), 1'b0);
    chk("rw_count", 64'(bus.count), 64'h8);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("rw_count", 64'(bus.count), 64'h8);
    end
    bus.out_ready = 1'b0;
    chk("rw_drop", 64'(bus.drop_cnt), 64'h2);
    exp_q = '{18'd26, 18'd27, 18'd30, 18'd31, 18'd32, 18'd33, 18'd34, 18'd35};
    for (int k = 0; k < 8; k++) pop_chk("rw_order", exp_q[k], 1'b0, 1'b0);
    chk("rw_empty", 64'(bus.out_valid), 64'h0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 48'(16 * (40 + k)), 1'b0);
    idle(4);
    chk("fl_pre", 64'(bus.count), 64'h3);
    cyc(1'b1, 48'(16 * 50), 1'b0);
    cyc(1'b1, 48'(16 * 51), 1'b0);
    idle(1);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    chk("fl_count", 64'(bus.count), 64'h0);
    chk("fl_valid", 64'(bus.out_valid), 64'h0);
    chk("fl_data", 64'(bus.out_data), 64'h0);
    chk("fl_ovf", 64'(bus.ovf), 64'h1);
    chk("fl_drop", 64'(bus.drop_cnt), 64'h2);
    idle(6);
    chk("fl_late", 64'(bus.count), 64'h0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 48'(16 * (60 + k)), 1'b1);
    idle(4);
    cyc(1'b1, 48'(16 * 70), 1'b0);
    cyc(1'b1, 48'(16 * 71), 1'b0);
    chk("ar_pre", 64'(bus.count), 64'h3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_data", 64'(bus.out_data), 64'h0);
    chk("ar_sat", 64'(bus.out_sat), 64'h0);
    chk("ar_carry", 64'(bus.out_carry), 64'h0);
    chk("ar_valid", 64'(bus.out_valid), 64'h0);
    chk("ar_count", 64'(bus.count), 64'h0);
    chk("ar_ovf", 64'(bus.ovf), 64'h0);
    chk("ar_drop", 64'(bus.drop_cnt), 64'h0);
    @(posedge clk); #1; rst = 1'b0;
    idle(6);
    chk("ar_late", 64'(bus.count), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
